// File: rtl/m23lc512_pkg.sv
// m23lc512_pkg: shared constants for the m23lc512 SPI serial SRAM slave.
//   - SPI opcodes (OP_READ, OP_WRITE, OP_RDMR, OP_WRMR)
//   - mode register encodings (MODE_BYTE, MODE_PAGE, MODE_SEQ, MODE_RSVD)
//   - FSM state enumeration (state_t)
package m23lc512_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDMR  = 8'h05;
    localparam logic [7:0] OP_WRMR  = 8'h01;

    // MODE[7:6] encodings
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD      = 3'd3,
        ST_WR      = 3'd4,
        ST_MODE_RD = 3'd5,
        ST_MODE_WR = 3'd6,
        ST_IGNORE  = 3'd7
    } state_t;

endpackage

// File: rtl/m23lc512_spi_sync.sv
// m23lc512_spi_sync: brings the asynchronous SPI pins into the HCLK domain.
// Each pin goes through a 2-flop synchronizer; SCK and CS_N additionally get
// one delay flop so their rise/fall pulses can be formed. The pulses are
// combinational off the synchronized/delayed pair, so logic that registers
// on them acts on the 3rd HCLK edge after the pin change.
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   cs_n, sck, si, hold_n  raw pins
//   si_s, hold_n_s         synchronized levels
//   sck_rise, sck_fall     one-cycle SCK edge pulses
//   cs_rise, cs_fall       one-cycle CS_N edge pulses
module m23lc512_spi_sync (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic cs_n,
    input  logic sck,
    input  logic si,
    input  logic hold_n,
    output logic si_s,
    output logic hold_n_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [1:0] cs_ff;
    logic [1:0] sck_ff;
    logic [1:0] si_ff;
    logic [1:0] hold_ff;
    logic       cs_d;
    logic       sck_d;

    // CS resets to "selected": if the master keeps CS_N low across a reset,
    // no fall is seen and the aborted transfer cannot restart by itself.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cs_ff   <= 2'b00;
            cs_d    <= 1'b0;
            sck_ff  <= 2'b00;
            sck_d   <= 1'b0;
            si_ff   <= 2'b00;
            hold_ff <= 2'b11;
        end else begin
            cs_ff   <= {cs_ff[0], cs_n};
            cs_d    <= cs_ff[1];
            sck_ff  <= {sck_ff[0], sck};
            sck_d   <= sck_ff[1];
            si_ff   <= {si_ff[0], si};
            hold_ff <= {hold_ff[0], hold_n};
        end
    end

    assign si_s     = si_ff[1];
    assign hold_n_s = hold_ff[1];
    assign sck_rise = sck_ff[1] & ~sck_d;
    assign sck_fall = ~sck_ff[1] & sck_d;
    assign cs_rise  = cs_ff[1] & ~cs_d;
    assign cs_fall  = ~cs_ff[1] & cs_d;

endmodule

// File: rtl/m23lc512.sv
// m23lc512: 64 KB SPI (mode 0) serial SRAM slave, 23LC512 command subset
// (READ, WRITE, RDMR, WRMR) with byte / page / sequential address modes.
// Optional feature macro: M23LC512_HOLD_EN enables the HOLD_N_SIO3 pause;
// without it HOLD_N_SIO3 is ignored.
// Ports:
//   HCLK, HRESETn  system clock, async active-low reset
//   CS_N, SCK      SPI chip select (active low) and clock
//   SI_SIO0        serial data in, sampled on SCK rise, MSB first
//   SO_SIO1        serial data out, updated on SCK fall, high-Z when idle
//   HOLD_N_SIO3    hold, active low
//   dbg_state      current FSM state (state_t encoding)
module m23lc512 #(
    parameter int ADDR_W = 16,
    parameter int PAGE_W = 5
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       CS_N,
    input  logic       SCK,
    input  logic       SI_SIO0,
    output logic       SO_SIO1,
    input  logic       HOLD_N_SIO3,
    output logic [2:0] dbg_state
);
    import m23lc512_pkg::*;

    localparam int               CNT_W     = $clog2(ADDR_W);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

    logic si_s, hold_n_s, sck_rise, sck_fall, cs_rise, cs_fall;
    logic hold_pin, hold_active;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-2:0]   shift_in;
    logic [ADDR_W-1:0]   addr_in, addr, addr_nxt;
    logic [7:0]          byte_in, tx_sr, rd_data;
    logic [1:0]          mode;
    logic                is_read, byte_done, so_en, so_q;
    logic                step, shift_out, byte_end, addr_end, mem_we;
    logic [7:0]          mem [0:(1<<ADDR_W)-1];

`ifdef M23LC512_HOLD_EN
    assign hold_pin    = HOLD_N_SIO3;
    assign hold_active = ~hold_n_s;
`else
    assign hold_pin    = 1'b1;
    assign hold_active = 1'b0;
    logic unused_hold;
    assign unused_hold = HOLD_N_SIO3 ^ hold_n_s;
`endif

    m23lc512_spi_sync u_sync (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .cs_n     (CS_N),
        .sck      (SCK),
        .si       (SI_SIO0),
        .hold_n   (hold_pin),
        .si_s     (si_s),
        .hold_n_s (hold_n_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    // While held, SCK edges are swallowed so every counter and shifter freezes.
    assign step      = sck_rise & ~hold_active;
    assign shift_out = sck_fall & ~hold_active;
    assign addr_in   = {shift_in, si_s};
    assign byte_in   = addr_in[7:0];
    assign byte_end  = step && (bit_cnt == BYTE_LAST);
    assign addr_end  = step && (bit_cnt == ADDR_LAST);

    always_comb begin
        addr_nxt = addr;
        case (mode)
            MODE_SEQ:  addr_nxt = addr + ADDR_W'(1);
            MODE_PAGE: addr_nxt = {addr[ADDR_W-1:PAGE_W], addr[PAGE_W-1:0] + PAGE_W'(1)};
            default:   addr_nxt = addr;
        endcase
    end

    // Prefetch: first byte at the freshly shifted address, later bytes at the
    // advanced address, so the byte is ready before the next SCK fall.
    assign rd_data = (state_q == ST_ADDR) ? mem[addr_in] : mem[addr_nxt];

    // In byte mode only the first data byte of a write is stored.
    assign mem_we = byte_end && (state_q == ST_WR) && !(mode == MODE_BYTE && byte_done);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_end) begin
                        case (byte_in)
                            OP_READ, OP_WRITE: state_d = ST_ADDR;
                            OP_RDMR:           state_d = ST_MODE_RD;
                            OP_WRMR:           state_d = ST_MODE_WR;
                            default:           state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: if (addr_end) state_d = is_read ? ST_RD : ST_WR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            addr      <= '0;
            mode      <= MODE_SEQ;
            is_read   <= 1'b0;
            byte_done <= 1'b0;
            so_en     <= 1'b0;
            so_q      <= 1'b0;
            tx_sr     <= '0;
        end else if (cs_rise || cs_fall) begin
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            so_en     <= 1'b0;
        end else begin
            if (step) begin
                shift_in <= addr_in[ADDR_W-2:0];
                bit_cnt  <= bit_cnt + CNT_W'(1);
                case (state_q)
                    ST_CMD: if (byte_end) begin
                        bit_cnt <= '0;
                        is_read <= (byte_in == OP_READ);
                        tx_sr   <= {mode, 6'b0};
                    end
                    ST_ADDR: if (addr_end) begin
                        bit_cnt <= '0;
                        addr    <= addr_in;
                        tx_sr   <= rd_data;
                    end
                    ST_RD: if (byte_end) begin
                        bit_cnt   <= '0;
                        addr      <= addr_nxt;
                        tx_sr     <= rd_data;
                        byte_done <= 1'b1;
                    end
                    ST_WR: if (byte_end) begin
                        bit_cnt   <= '0;
                        addr      <= addr_nxt;
                        byte_done <= 1'b1;
                    end
                    ST_MODE_RD: if (byte_end) begin
                        bit_cnt <= '0;
                        tx_sr   <= {mode, 6'b0};
                    end
                    ST_MODE_WR: if (byte_end) begin
                        bit_cnt <= '0;
                        if (byte_in[7:6] != MODE_RSVD) mode <= byte_in[7:6];
                    end
                    default: bit_cnt <= '0;
                endcase
            end
            if (shift_out && (state_q == ST_RD || state_q == ST_MODE_RD)) begin
                so_q  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
                // Byte mode read: release SO once the single byte has gone out.
                so_en <= !(state_q == ST_RD && mode == MODE_BYTE && byte_done);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) mem[addr] <= byte_in;
    end

    assign SO_SIO1   = (so_en && !hold_active) ? so_q : 1'bz;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_m23lc512.sv
`timescale 1ns/1ps
module tb_m23lc512;
  import m23lc512_pkg::*;

  localparam int HALF = 8;  // HCLK cycles per SCK phase

  logic       hclk = 1'b0;
  logic       hresetn = 1'b0;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic       si = 1'b0;
  logic       hold_n = 1'b1;
  wire        so;
  logic [2:0] dbg_state;

  typedef struct {
    bit         is_state;
    logic [2:0] exp;
  } probe_t;

  // bit 8 set: the whole byte must read as high-Z
  logic [8:0] exp_q[$];
  probe_t     probe_q[$];
  logic       rd_active = 1'b0;
  logic       done = 1'b0;
  event       probe_ev;
  event       done_ev;
  int         checks = 0;
  int         errors = 0;

  m23lc512 dut (
    .HCLK        (hclk),
    .HRESETn     (hresetn),
    .CS_N        (cs_n),
    .SCK         (sck),
    .SI_SIO0     (si),
    .SO_SIO1     (so),
    .HOLD_N_SIO3 (hold_n),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge hclk);
  endtask

  task automatic bit_clk(input logic b);
    si = b;
    wait_clk(HALF);
    sck = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int n = 8);
    for (int i = 7; i > 7 - n; i--) bit_clk(b[i]);
  endtask

  task automatic rd_bits(input int n);
    rd_active = 1'b1;
    for (int i = 0; i < n; i++) bit_clk(1'b0);
    rd_active = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] e);
    exp_q.push_back({1'b0, e});
    rd_bits(8);
  endtask

  task automatic expect_hiz_byte();
    exp_q.push_back(9'h100);
    rd_bits(8);
  endtask

  task automatic probe_so();
    probe_t p;
    p.is_state = 1'b0;
    p.exp = 3'd0;
    probe_q.push_back(p);
    -> probe_ev;
    #1;
  endtask

  task automatic probe_state(input logic [2:0] s);
    probe_t p;
    p.is_state = 1'b1;
    p.exp = s;
    probe_q.push_back(p);
    -> probe_ev;
    #1;
  endtask

  task automatic begin_xfer();
    wait_clk(2);
    cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic end_xfer();
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic cmd_addr(input logic [7:0] op, input logic [15:0] a);
    begin_xfer();
    send(op);
    send(a[15:8]);
    send(a[7:0]);
  endtask

  task automatic wrmr(input logic [7:0] v);
    begin_xfer();
    send(OP_WRMR);
    send(v);
    end_xfer();
  endtask

  task automatic rdmr_check(input logic [7:0] v);
    begin_xfer();
    send(OP_RDMR);
    expect_byte(v);
    end_xfer();
  endtask

  // scoreboard / monitor: sole owner of checks and errors
  initial begin
    logic [7:0] sr;
    int         nb;
    int         nz;
    logic [8:0] e;
    probe_t     p;
    sr = 8'h00;
    nb = 0;
    nz = 0;
    forever begin
      @(posedge sck or probe_ev or done_ev);
      if (done) begin
        checks++;
        if (exp_q.size() != 0 || nb != 0) begin
          errors++;
          $display("FAIL drain: %0d bytes still expected, %0d bits pending, required 0 and 0", exp_q.size(), nb);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      while (probe_q.size() != 0) begin
        p = probe_q.pop_front();
        checks++;
        if (p.is_state) begin
          if (dbg_state !== p.exp) begin
            errors++;
            $display("FAIL state @%0t: got %0d, required %0d", $time, dbg_state, p.exp);
          end
        end else if (so !== 1'bz) begin
          errors++;
          $display("FAIL so_hiz @%0t: got %b, required z", $time, so);
        end
      end
      if (rd_active && sck === 1'b1) begin
        sr = {sr[6:0], so};
        if (so === 1'bz) nz++;
        nb++;
        if (nb == 8) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_byte @%0t: got %h with nothing expected", $time, sr);
          end else begin
            e = exp_q.pop_front();
            if (e[8]) begin
              if (nz != 8) begin
                errors++;
                $display("FAIL rd_hiz @%0t: %0d of 8 bits high-Z, required 8", $time, nz);
              end
            end else if (nz != 0 || sr !== e[7:0]) begin
              errors++;
              $display("FAIL rd_byte @%0t: got %h (%0d z bits), required %h", $time, sr, nz, e[7:0]);
            end
          end
          nb = 0;
          nz = 0;
        end
      end
    end
  end

  // stimulus
  initial begin
    wait_clk(3);
    hresetn = 1'b1;
    wait_clk(5);

    // reset state, RDMR default = sequential
    probe_so();
    probe_state(3'(ST_IDLE));
    begin_xfer();
    probe_so();
    send(OP_RDMR);
    expect_byte(8'h40);
    expect_byte(8'h40);
    end_xfer();
    probe_so();

    // basic sequential write / read
    cmd_addr(OP_WRITE, 16'h0010);
    send(8'hA5); send(8'h5A); send(8'hC3);
    end_xfer();
    cmd_addr(OP_READ, 16'h0010);
    expect_byte(8'hA5); expect_byte(8'h5A); expect_byte(8'hC3);
    end_xfer();
    probe_so();

    // sequential wrap at the top of memory
    cmd_addr(OP_WRITE, 16'hFFFF);
    send(8'h11); send(8'h22);
    end_xfer();
    cmd_addr(OP_READ, 16'h0000);
    expect_byte(8'h22);
    end_xfer();
    cmd_addr(OP_READ, 16'hFFFF);
    expect_byte(8'h11); expect_byte(8'h22);
    end_xfer();

    // background data for later "unchanged" checks
    cmd_addr(OP_WRITE, 16'h0100);
    send(8'h01); send(8'h3C);
    end_xfer();
    cmd_addr(OP_WRITE, 16'h0200);
    send(8'h12); send(8'h5E);
    end_xfer();

    // page mode: 0x001F wraps to 0x0000
    wrmr(8'h80);
    rdmr_check(8'h80);
    cmd_addr(OP_WRITE, 16'h001F);
    send(8'h77); send(8'h88);
    end_xfer();
    cmd_addr(OP_READ, 16'h0000);
    expect_byte(8'h88);
    end_xfer();
    cmd_addr(OP_READ, 16'h001F);
    expect_byte(8'h77); expect_byte(8'h88);
    end_xfer();

    // byte mode: second write byte dropped, second read byte high-Z
    wrmr(8'h00);
    rdmr_check(8'h00);
    cmd_addr(OP_WRITE, 16'h0100);
    send(8'h99); send(8'hAA);
    end_xfer();
    cmd_addr(OP_READ, 16'h0100);
    expect_byte(8'h99);
    expect_hiz_byte();
    end_xfer();
    cmd_addr(OP_READ, 16'h0101);
    expect_byte(8'h3C);
    end_xfer();

    // partial byte discarded at CS_N rise; reserved mode ignored
    wrmr(8'h40);
    cmd_addr(OP_WRITE, 16'h0200);
    send(8'hB1);
    send(8'hF0, 4);
    end_xfer();
    cmd_addr(OP_READ, 16'h0200);
    expect_byte(8'hB1); expect_byte(8'h5E);
    end_xfer();
    wrmr(8'hC0);
    rdmr_check(8'h40);

`ifdef M23LC512_HOLD_EN
    // hold mid-read: SCK keeps toggling, SO released, no bits lost
    cmd_addr(OP_READ, 16'h0010);
    expect_byte(8'hA5);
    exp_q.push_back({1'b0, 8'h5A});
    rd_bits(3);
    wait_clk(4);
    hold_n = 1'b0;
    wait_clk(6);
    probe_so();
    for (int i = 0; i < 10; i++) bit_clk(1'b1);
    probe_so();
    wait_clk(4);
    hold_n = 1'b1;
    wait_clk(4);
    rd_bits(5);
    expect_byte(8'hC3);
    end_xfer();
`else
    // hold pin has no effect in this build
    cmd_addr(OP_READ, 16'h0010);
    expect_byte(8'hA5);
    exp_q.push_back({1'b0, 8'h5A});
    rd_bits(3);
    hold_n = 1'b0;
    rd_bits(5);
    hold_n = 1'b1;
    expect_byte(8'hC3);
    end_xfer();
`endif

    // reset mid-write: back to IDLE, MODE sequential, no restart without CS fall
    wrmr(8'h80);
    cmd_addr(OP_WRITE, 16'h0300);
    send(8'hFF, 4);
    hresetn = 1'b0;
    wait_clk(3);
    probe_state(3'(ST_IDLE));
    probe_so();
    hresetn = 1'b1;
    wait_clk(4);
    send(OP_RDMR);
    send(8'h00);
    probe_state(3'(ST_IDLE));
    probe_so();
    end_xfer();
    rdmr_check(8'h40);

    wait_clk(4);
    done = 1'b1;
    -> done_ev;
  end

endmodule
